// File: rtl/alu_issue_stage.sv
// Registered ALU issue stage: operand select, 2-entry skid buffer, writeback bypass on held ops.
// Optional performance counters enabled by defining ALU_ISSUE_PERF_EN.
module alu_issue_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned RIDX_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [RIDX_W-1:0] in_rs1_idx,
    input  logic [RIDX_W-1:0] in_rs2_idx,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [1:0]        in_src1_sel,
    input  logic [1:0]        in_src2_sel,
    input  logic [2:0]        in_alu_sel,
    input  logic              in_A_L,
    input  logic              in_L_R,
    input  logic              in_S_U,
    input  logic              in_Add_Sub,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic              in_wen,
    input  logic              fwd_valid,
    input  logic [RIDX_W-1:0] fwd_rd,
    input  logic [XLEN-1:0]   fwd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   alu_a,
    output logic [XLEN-1:0]   alu_b,
    output logic [2:0]        alu_sel,
    output logic              alu_A_L,
    output logic              alu_L_R,
    output logic              alu_S_U,
    output logic              alu_Add_Sub,
    output logic [XLEN-1:0]   out_pc,
    output logic [RIDX_W-1:0] out_rd,
    output logic              out_wen
`ifdef ALU_ISSUE_PERF_EN
    ,
    output logic [31:0]       perf_issue_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int unsigned CNT_W = 32;
    localparam logic [XLEN-1:0] SHAMT_MASK = XLEN'(31);

    typedef struct packed {
        logic [XLEN-1:0]   a;
        logic [XLEN-1:0]   b;
        logic [XLEN-1:0]   pc;
        logic [RIDX_W-1:0] rs1_idx;
        logic [RIDX_W-1:0] rs2_idx;
        logic [RIDX_W-1:0] rd;
        logic [1:0]        src1_sel;
        logic [1:0]        src2_sel;
        logic [2:0]        sel;
        logic              a_l;
        logic              l_r;
        logic              s_u;
        logic              add_sub;
        logic              wen;
    } entry_t;

    function automatic logic is_shift(input logic [2:0] sel);
        return (sel == 3'b001) || (sel == 3'b101);
    endfunction

    // Replace register-sourced operands whose index matches the writeback bypass (never x0).
    function automatic entry_t apply_bypass(input entry_t e, input logic fv,
                                            input logic [RIDX_W-1:0] frd,
                                            input logic [XLEN-1:0] fd);
        entry_t r;
        r = e;
        if (fv && (frd != '0) && (frd == e.rs1_idx) && (e.src1_sel == 2'd0)) begin
            r.a = fd;
        end
        if (fv && (frd != '0) && (frd == e.rs2_idx) && (e.src2_sel == 2'd0)) begin
            r.b = is_shift(e.sel) ? (fd & SHAMT_MASK) : fd;
        end
        return r;
    endfunction

    entry_t main_q, main_d, skid_q, skid_d, cap_c, main_byp_c, skid_byp_c;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept_c, issue_c;

    assign accept_c = in_valid & in_ready_q;
    assign issue_c  = main_valid_q & out_ready;

    // Build the incoming entry: operand muxes, capture-time bypass, shift-amount mask.
    always_comb begin
        cap_c          = '0;
        cap_c.pc       = in_pc;
        cap_c.rs1_idx  = in_rs1_idx;
        cap_c.rs2_idx  = in_rs2_idx;
        cap_c.rd       = in_rd;
        cap_c.src1_sel = in_src1_sel;
        cap_c.src2_sel = in_src2_sel;
        cap_c.sel      = in_alu_sel;
        cap_c.a_l      = in_A_L;
        cap_c.l_r      = in_L_R;
        cap_c.s_u      = in_S_U;
        cap_c.add_sub  = in_Add_Sub;
        cap_c.wen      = in_wen;
        case (in_src1_sel)
            2'd0:    cap_c.a = in_rs1_data;
            2'd1:    cap_c.a = in_pc;
            default: cap_c.a = '0;
        endcase
        case (in_src2_sel)
            2'd0:    cap_c.b = in_rs2_data;
            2'd1:    cap_c.b = in_imm;
            2'd2:    cap_c.b = XLEN'(4);
            default: cap_c.b = '0;
        endcase
        cap_c = apply_bypass(cap_c, fwd_valid, fwd_rd, fwd_data);
        if (is_shift(in_alu_sel)) begin
            cap_c.b = cap_c.b & SHAMT_MASK;
        end
    end

    assign main_byp_c = apply_bypass(main_q, fwd_valid, fwd_rd, fwd_data);
    assign skid_byp_c = apply_bypass(skid_q, fwd_valid, fwd_rd, fwd_data);

    // Skid-buffer next state.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (issue_c) begin
                main_d       = skid_byp_c;
                skid_valid_d = 1'b0;
            end else begin
                main_d = main_byp_c;
                skid_d = skid_byp_c;
            end
        end else if (!main_valid_q || issue_c) begin
            main_valid_d = accept_c;
            if (accept_c) begin
                main_d = cap_c;
            end
        end else begin
            main_d = main_byp_c;
            if (accept_c) begin
                skid_d       = cap_c;
                skid_valid_d = 1'b1;
            end
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = main_valid_q;
    assign alu_a       = main_q.a;
    assign alu_b       = main_q.b;
    assign alu_sel     = main_q.sel;
    assign alu_A_L     = main_q.a_l;
    assign alu_L_R     = main_q.l_r;
    assign alu_S_U     = main_q.s_u;
    assign alu_Add_Sub = main_q.add_sub;
    assign out_pc      = main_q.pc;
    assign out_rd      = main_q.rd;
    assign out_wen     = main_q.wen;

`ifdef ALU_ISSUE_PERF_EN
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d, stall_cnt_q, stall_cnt_d;

    // Saturating issue / stall counters; flush does not touch them.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (issue_c && (issue_cnt_q != '1)) begin
            issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
        if (main_valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_issue_cnt = issue_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage; perf-counter test built when ALU_ISSUE_PERF_EN is defined.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [4:0]  in_rs1_idx, in_rs2_idx, in_rd;
    logic [1:0]  in_src1_sel, in_src2_sel;
    logic [2:0]  in_alu_sel;
    logic        in_A_L, in_L_R, in_S_U, in_Add_Sub, in_wen;
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [31:0] fwd_data;
    logic        out_valid, out_ready;
    logic [31:0] alu_a, alu_b, out_pc;
    logic [2:0]  alu_sel;
    logic        alu_A_L, alu_L_R, alu_S_U, alu_Add_Sub;
    logic [4:0]  out_rd;
    logic        out_wen;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_issue_cnt, perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
        .in_rs1_idx(in_rs1_idx), .in_rs2_idx(in_rs2_idx),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_src1_sel(in_src1_sel), .in_src2_sel(in_src2_sel), .in_alu_sel(in_alu_sel),
        .in_A_L(in_A_L), .in_L_R(in_L_R), .in_S_U(in_S_U), .in_Add_Sub(in_Add_Sub),
        .in_rd(in_rd), .in_wen(in_wen),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_A_L(alu_A_L), .alu_L_R(alu_L_R), .alu_S_U(alu_S_U), .alu_Add_Sub(alu_Add_Sub),
        .out_pc(out_pc), .out_rd(out_rd), .out_wen(out_wen)
`ifdef ALU_ISSUE_PERF_EN
        , .perf_issue_cnt(perf_issue_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] pc, input logic [4:0] r1i, input logic [31:0] r1d,
                          input logic [4:0] r2i, input logic [31:0] r2d, input logic [31:0] imm,
                          input logic [1:0] s1, input logic [1:0] s2, input logic [2:0] sel);
        in_valid    = 1'b1;
        in_pc       = pc;
        in_rs1_idx  = r1i;
        in_rs1_data = r1d;
        in_rs2_idx  = r2i;
        in_rs2_data = r2d;
        in_imm      = imm;
        in_src1_sel = s1;
        in_src2_sel = s2;
        in_alu_sel  = sel;
        in_rd       = 5'd9;
        in_wen      = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; fwd_valid = 1'b0;
        fwd_rd = '0; fwd_data = '0;
        in_A_L = 1'b0; in_L_R = 1'b0; in_S_U = 1'b0; in_Add_Sub = 1'b0;
        set_op(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 2'd0, 2'd0, 3'd0);
        in_valid = 1'b0;
        tick(); tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got %0b want 0", in_ready); end
        n_checks++; if ({alu_a, alu_b, out_pc} !== 96'h0) begin n_fail++; $display("FAIL reset_data got %h %h %h want 0", alu_a, alu_b, out_pc); end
        n_checks++; if ({alu_sel, out_rd, out_wen} !== 9'h0) begin n_fail++; $display("FAIL reset_ctrl got %h %h %b want 0", alu_sel, out_rd, out_wen); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready got %0b want 1", in_ready); end
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        set_op(32'h40, 5'd1, 32'd5, 5'd2, 32'd0, 32'd7, 2'd0, 2'd1, 3'b000);
        tick();
        n_checks++; if (out_valid !== 1'b1 || alu_a !== 32'd5 || alu_b !== 32'd7 || alu_sel !== 3'b000)
            begin n_fail++; $display("FAIL basic_first got v=%0b a=%h b=%h sel=%b want 1/5/7/000", out_valid, alu_a, alu_b, alu_sel); end
        set_op(32'h44, 5'd1, 32'd10, 5'd2, 32'd0, 32'd1, 2'd0, 2'd1, 3'b000);
        tick();
        n_checks++; if (out_valid !== 1'b1 || alu_a !== 32'd10 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL basic_stream2 got v=%0b a=%h rdy=%0b want 1/a/1", out_valid, alu_a, in_ready); end
        set_op(32'h48, 5'd1, 32'd20, 5'd2, 32'd0, 32'd1, 2'd0, 2'd1, 3'b000);
        tick();
        n_checks++; if (out_valid !== 1'b1 || alu_a !== 32'd20 || out_pc !== 32'h48)
            begin n_fail++; $display("FAIL basic_stream3 got v=%0b a=%h pc=%h want 1/14/48", out_valid, alu_a, out_pc); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        set_op(32'h100, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 2'd1, 2'd3, 3'b000);
        tick();
        set_op(32'h200, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 2'd1, 2'd3, 3'b000);
        tick();
        n_checks++; if (in_ready !== 1'b0 || out_pc !== 32'h100 || alu_a !== 32'h100)
            begin n_fail++; $display("FAIL skid_full got rdy=%0b pc=%h a=%h want 0/100/100", in_ready, out_pc, alu_a); end
        set_op(32'h300, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 2'd1, 2'd3, 3'b000);
        tick();
        n_checks++; if (in_ready !== 1'b0 || out_pc !== 32'h100)
            begin n_fail++; $display("FAIL skid_holdoff got rdy=%0b pc=%h want 0/100", in_ready, out_pc); end
        out_ready = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL skid_to_main got v=%0b pc=%h rdy=%0b want 1/200/1", out_valid, out_pc, in_ready); end
        tick();
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h300)
            begin n_fail++; $display("FAIL third_op got v=%0b pc=%h want 1/300", out_valid, out_pc); end
        in_valid = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL order_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_operands();
        out_ready = 1'b1;
        set_op(32'h0, 5'd1, 32'd0, 5'd2, 32'h00000123, 32'd0, 2'd0, 2'd0, 3'b101);
        tick();
        n_checks++; if (alu_b !== 32'h3 || alu_sel !== 3'b101)
            begin n_fail++; $display("FAIL shift_mask got b=%h sel=%b want 3/101", alu_b, alu_sel); end
        set_op(32'h0, 5'd1, 32'd0, 5'd2, 32'h55, 32'h66, 2'd0, 2'd2, 3'b000);
        tick();
        n_checks++; if (alu_b !== 32'd4) begin n_fail++; $display("FAIL src2_const4 got %h want 4", alu_b); end
        set_op(32'h80000000, 5'd1, 32'h11, 5'd2, 32'h22, 32'h0, 2'd1, 2'd3, 3'b000);
        tick();
        n_checks++; if (alu_a !== 32'h80000000 || alu_b !== 32'h0)
            begin n_fail++; $display("FAIL src1_pc got a=%h b=%h want 80000000/0", alu_a, alu_b); end
        set_op(32'h4, 5'd1, 32'h11, 5'd2, 32'h22, 32'h0, 2'd2, 2'd0, 3'b000);
        tick();
        n_checks++; if (alu_a !== 32'h0 || alu_b !== 32'h22)
            begin n_fail++; $display("FAIL src1_zero got a=%h b=%h want 0/22", alu_a, alu_b); end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        set_op(32'h0, 5'd3, 32'h11, 5'd2, 32'h0, 32'h0, 2'd0, 2'd3, 3'b000);
        fwd_valid = 1'b1; fwd_rd = 5'd3; fwd_data = 32'hDEADBEEF;
        tick();
        n_checks++; if (alu_a !== 32'hDEADBEEF) begin n_fail++; $display("FAIL byp_capture got %h want deadbeef", alu_a); end
        in_valid = 1'b0; fwd_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        set_op(32'h10, 5'd0, 32'h0, 5'd4, 32'h50, 32'h0, 2'd0, 2'd0, 3'b000);
        tick();
        n_checks++; if (alu_b !== 32'h50) begin n_fail++; $display("FAIL byp_held_pre got %h want 50", alu_b); end
        set_op(32'h20, 5'd6, 32'h1, 5'd6, 32'h2, 32'h0, 2'd0, 2'd0, 3'b001);
        tick();
        in_valid = 1'b0;
        fwd_valid = 1'b1; fwd_rd = 5'd4; fwd_data = 32'd9;
        tick();
        n_checks++; if (alu_b !== 32'd9) begin n_fail++; $display("FAIL byp_held got %h want 9", alu_b); end
        fwd_rd = 5'd0; fwd_data = 32'h77;
        tick();
        n_checks++; if (alu_a !== 32'h0 || alu_b !== 32'd9)
            begin n_fail++; $display("FAIL byp_x0 got a=%h b=%h want 0/9", alu_a, alu_b); end
        fwd_rd = 5'd6; fwd_data = 32'h00000ABC;
        tick();
        fwd_valid = 1'b0; out_ready = 1'b1;
        tick();
        n_checks++; if (out_pc !== 32'h20 || alu_a !== 32'hABC || alu_b !== 32'h1C)
            begin n_fail++; $display("FAIL byp_skid got pc=%h a=%h b=%h want 20/abc/1c", out_pc, alu_a, alu_b); end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        set_op(32'h10, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 2'd1, 2'd3, 3'b000);
        tick();
        set_op(32'h20, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 2'd1, 2'd3, 3'b000);
        tick();
        set_op(32'h30, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 2'd1, 2'd3, 3'b000);
        flush = 1'b1;
        tick();
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL flush_state got v=%0b rdy=%0b want 0/1", out_valid, in_ready); end
        n_checks++; if (out_pc !== 32'h10) begin n_fail++; $display("FAIL flush_keeps_data got %h want 10", out_pc); end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_issue cyc %0d got %0b want 0", i, out_valid); end
        end
    endtask

`ifdef ALU_ISSUE_PERF_EN
    task automatic test_perf();
        rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
        n_checks++; if (perf_issue_cnt !== 32'd0 || perf_stall_cnt !== 32'd0)
            begin n_fail++; $display("FAIL perf_reset got %0d/%0d want 0/0", perf_issue_cnt, perf_stall_cnt); end
        out_ready = 1'b0;
        set_op(32'h10, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 2'd1, 2'd3, 3'b000);
        tick();
        set_op(32'h20, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 2'd1, 2'd3, 3'b000);
        tick();
        in_valid = 1'b0;
        tick(); tick();
        out_ready = 1'b1;
        tick(); tick(); tick();
        n_checks++; if (perf_stall_cnt !== 32'd3 || perf_issue_cnt !== 32'd2)
            begin n_fail++; $display("FAIL perf_counts got stall=%0d issue=%0d want 3/2", perf_stall_cnt, perf_issue_cnt); end
        set_op(32'h40, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 2'd1, 2'd3, 3'b000);
        tick();
        rst_n = 1'b0;
        tick();
        n_checks++; if (perf_stall_cnt !== 32'd0 || perf_issue_cnt !== 32'd0 || out_valid !== 1'b0)
            begin n_fail++; $display("FAIL perf_midreset got %0d/%0d v=%0b want 0/0/0", perf_stall_cnt, perf_issue_cnt, out_valid); end
        in_valid = 1'b0; rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_operands();
        test_bypass();
        test_flush();
`ifdef ALU_ISSUE_PERF_EN
        test_perf();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
